// File: rtl/sequenciador_servo.sv
// Command sequencer for the servo PWM generator: queues position codes in a FIFO
// and applies each to largura, holding it for a fixed number of PWM periods.
module sequenciador_servo #(
  parameter int conf_periodo    = 1250,
  parameter int periodos_espera = 40,
  parameter int profundidade    = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cmd_valido,
  input  logic [1:0]                    cmd_posicao,
  output logic                          cmd_pronto,
  output logic [1:0]                    largura,
  output logic                          ocupado,
  output logic                          fim_movimento,
  output logic                          erro_posicao,
  output logic [$clog2(profundidade):0] nivel
);

  localparam int AW = $clog2(profundidade);
  localparam logic [31:0] T_ULTIMO = 32'(conf_periodo * periodos_espera) - 32'd1;
  localparam logic [AW:0] N_CHEIO  = (AW + 1)'(profundidade);
  localparam logic [AW:0] UM       = (AW + 1)'(1);

  typedef enum logic [1:0] {
    OCIOSO,
    ESPERA,
    FIM
  } estado_t;

  estado_t     estado_q, estado_d;
  logic [AW:0] cab_q, cab_d;
  logic [AW:0] cauda_q, cauda_d;
  logic [1:0]  largura_q, largura_d;
  logic [31:0] timer_q, timer_d;
  logic        erro_q, erro_d;
  logic [1:0]  mem_q [profundidade];

  logic        cheio;
  logic        vazio;
  logic        aceita;
  logic        push;
  logic [1:0]  cabeca;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign nivel  = cauda_q - cab_q;
  assign cheio  = (nivel == N_CHEIO);
  assign vazio  = (nivel == '0);
  assign aceita = cmd_valido && !cheio;
  assign push   = aceita && (cmd_posicao != 2'b11);
  assign cabeca = mem_q[cab_q[AW-1:0]];

  assign cmd_pronto    = !cheio;
  assign largura       = largura_q;
  assign fim_movimento = (estado_q == FIM);
  assign ocupado       = (estado_q != OCIOSO) || !vazio;
  assign erro_posicao  = erro_q;

  always_comb begin
    estado_d  = estado_q;
    cab_d     = cab_q;
    cauda_d   = push ? cauda_q + UM : cauda_q;
    largura_d = largura_q;
    timer_d   = timer_q;
    erro_d    = erro_q | (aceita && (cmd_posicao == 2'b11));
    case (estado_q)
      OCIOSO: begin
        if (!vazio) begin
          cab_d = cab_q + UM;
          // A command for the position already held completes without a settle.
          if (cabeca != largura_q) begin
            largura_d = cabeca;
            timer_d   = '0;
            estado_d  = ESPERA;
          end else begin
            estado_d = FIM;
          end
        end
      end
      ESPERA: begin
        if (timer_q == T_ULTIMO) estado_d = FIM;
        else                     timer_d  = timer_q + 32'd1;
      end
      FIM:     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      cab_q     <= '0;
      cauda_q   <= '0;
      largura_q <= 2'b00;
      timer_q   <= '0;
      erro_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cab_q     <= cab_d;
      cauda_q   <= cauda_d;
      largura_q <= largura_d;
      timer_q   <= timer_d;
      erro_q    <= erro_d;
    end
  end

  // FIFO storage is plain data; emptiness is tracked by the pointers alone.
  always_ff @(posedge clock) begin
    if (push) mem_q[cauda_q[AW-1:0]] <= cmd_posicao;
  end

endmodule

// File: tb/tb_sequenciador_servo.sv
// Self-checking bench for sequenciador_servo with T = 4 x 2 = 8 cycles, FIFO depth 4.
// Accepted commands go to a scoreboard; each fim_movimento pulse pops and checks largura.
module tb_sequenciador_servo;

  localparam int CP   = 4;
  localparam int PE   = 2;
  localparam int PROF = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valido;
  logic [1:0] cmd_posicao;
  logic       cmd_pronto;
  logic [1:0] largura;
  logic       ocupado;
  logic       fim_movimento;
  logic       erro_posicao;
  logic [2:0] nivel;

  int         n_testes = 0;
  int         n_falhas = 0;
  int         n_fim    = 0;
  logic [1:0] sb [$];

  sequenciador_servo #(
    .conf_periodo    (CP),
    .periodos_espera (PE),
    .profundidade    (PROF)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valido    (cmd_valido),
    .cmd_posicao   (cmd_posicao),
    .cmd_pronto    (cmd_pronto),
    .largura       (largura),
    .ocupado       (ocupado),
    .fim_movimento (fim_movimento),
    .erro_posicao  (erro_posicao),
    .nivel         (nivel)
  );

  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_testes++;
    if (obs !== esp) begin
      n_falhas++;
      $display("FAIL %s: observado=%0d esperado=%0d", tag, obs, esp);
    end
  endtask

  task automatic passo(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Inputs only change 1 time unit after a rising edge, so the values seen on
  // the falling edge are exactly those the next rising edge will sample.
  always @(negedge clock) begin
    if (!reset) begin
      if (fim_movimento) begin
        n_fim++;
        verifica("sb_disponivel", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) verifica("fim_largura", 32'(largura), 32'(sb.pop_front()));
      end
      if (cmd_valido && cmd_pronto && cmd_posicao != 2'b11) sb.push_back(cmd_posicao);
    end
  end

  task automatic aplica_reset(input logic com_cmd);
    reset       = 1'b1;
    sb.delete();
    cmd_valido  = com_cmd;
    cmd_posicao = 2'b01;
    passo(1);
    reset      = 1'b0;
    cmd_valido = 1'b0;
    verifica("rst_largura", 32'(largura), 32'd0);
    verifica("rst_nivel", 32'(nivel), 32'd0);
    verifica("rst_ocupado", 32'(ocupado), 32'd0);
    verifica("rst_fim", 32'(fim_movimento), 32'd0);
    verifica("rst_erro", 32'(erro_posicao), 32'd0);
    verifica("rst_pronto", 32'(cmd_pronto), 32'd1);
  endtask

  task automatic espera_ocioso(input int limite);
    int k = 0;
    while (ocupado && k < limite) begin
      passo(1);
      k++;
    end
    verifica("ocioso_timeout", 32'(ocupado), 32'd0);
  endtask

  initial begin
    int f0;
    int k;
    reset       = 1'b1;
    cmd_valido  = 1'b0;
    cmd_posicao = 2'b00;
    passo(2);

    // Single command 01; a command presented during reset must be dropped.
    aplica_reset(1'b1);
    f0 = n_fim;
    cmd_valido = 1'b1; cmd_posicao = 2'b01;
    passo(1);  // E0
    cmd_valido = 1'b0;
    verifica("t1_nivel_e0", 32'(nivel), 32'd1);
    verifica("t1_ocupado_e0", 32'(ocupado), 32'd1);
    verifica("t1_largura_e0", 32'(largura), 32'd0);
    passo(1);  // E1
    verifica("t1_largura_e1", 32'(largura), 32'd1);
    passo(7);  // E8
    verifica("t1_fim_e8", 32'(fim_movimento), 32'd0);
    passo(1);  // E9
    verifica("t1_fim_e9", 32'(fim_movimento), 32'd1);
    verifica("t1_ocupado_e9", 32'(ocupado), 32'd1);
    passo(1);  // E10
    verifica("t1_fim_e10", 32'(fim_movimento), 32'd0);
    verifica("t1_ocupado_e10", 32'(ocupado), 32'd0);
    verifica("t1_nfim", 32'(n_fim - f0), 32'd1);

    // Burst 10, 00, 01 on consecutive cycles.
    aplica_reset(1'b0);
    f0 = n_fim;
    cmd_valido = 1'b1; cmd_posicao = 2'b10;
    passo(1);  // E0
    cmd_posicao = 2'b00;
    passo(1);  // E1
    verifica("t2_largura_e1", 32'(largura), 32'd2);
    cmd_posicao = 2'b01;
    passo(1);  // E2
    cmd_valido = 1'b0;
    verifica("t2_nivel_e2", 32'(nivel), 32'd2);
    passo(8);  // E10
    verifica("t2_largura_e10", 32'(largura), 32'd2);
    passo(1);  // E11
    verifica("t2_largura_e11", 32'(largura), 32'd0);
    passo(9);  // E20
    verifica("t2_largura_e20", 32'(largura), 32'd0);
    passo(1);  // E21
    verifica("t2_largura_e21", 32'(largura), 32'd1);
    espera_ocioso(40);
    verifica("t2_nfim", 32'(n_fim - f0), 32'd3);

    // Backpressure: five commands held valid while the first one settles.
    aplica_reset(1'b0);
    f0 = n_fim;
    cmd_valido = 1'b1; cmd_posicao = 2'b01;
    passo(1);  // E0
    cmd_valido = 1'b0;
    passo(1);  // E1
    cmd_valido = 1'b1; cmd_posicao = 2'b10;
    passo(1);  // E2
    cmd_posicao = 2'b00;
    passo(1);  // E3
    cmd_posicao = 2'b01;
    passo(1);  // E4
    cmd_posicao = 2'b10;
    passo(1);  // E5
    cmd_posicao = 2'b00;
    verifica("t3_nivel_cheio", 32'(nivel), 32'd4);
    verifica("t3_pronto_cheio", 32'(cmd_pronto), 32'd0);
    k = 0;
    while (!cmd_pronto && k < 20) begin
      passo(1);
      k++;
    end
    verifica("t3_pronto_volta", 32'(k), 32'd6);
    passo(1);  // E12: fifth command accepted
    cmd_valido = 1'b0;
    verifica("t3_nivel_e12", 32'(nivel), 32'd4);
    espera_ocioso(200);
    verifica("t3_nfim", 32'(n_fim - f0), 32'd6);
    verifica("t3_sb_vazio", 32'(sb.size()), 32'd0);
    verifica("t3_largura_final", 32'(largura), 32'd0);

    // Illegal code 11.
    f0 = n_fim;
    verifica("t4_pronto", 32'(cmd_pronto), 32'd1);
    cmd_valido = 1'b1; cmd_posicao = 2'b11;
    passo(1);
    cmd_valido = 1'b0;
    verifica("t4_erro", 32'(erro_posicao), 32'd1);
    verifica("t4_nivel", 32'(nivel), 32'd0);
    verifica("t4_largura", 32'(largura), 32'd0);
    verifica("t4_ocupado", 32'(ocupado), 32'd0);
    passo(5);
    verifica("t4_erro_sticky", 32'(erro_posicao), 32'd1);
    verifica("t4_nfim", 32'(n_fim - f0), 32'd0);

    // Same-position command right after reset.
    aplica_reset(1'b0);
    f0 = n_fim;
    cmd_valido = 1'b1; cmd_posicao = 2'b00;
    passo(1);  // E0
    cmd_valido = 1'b0;
    passo(1);  // E1
    verifica("t5_fim_e1", 32'(fim_movimento), 32'd1);
    verifica("t5_largura_e1", 32'(largura), 32'd0);
    passo(1);  // E2
    verifica("t5_fim_e2", 32'(fim_movimento), 32'd0);
    verifica("t5_ocupado_e2", 32'(ocupado), 32'd0);
    verifica("t5_nfim", 32'(n_fim - f0), 32'd1);

    // Reset three cycles into the settle with two commands still queued.
    aplica_reset(1'b0);
    cmd_valido = 1'b1; cmd_posicao = 2'b01;
    passo(1);  // E0
    cmd_posicao = 2'b10;
    passo(1);  // E1
    cmd_posicao = 2'b00;
    passo(1);  // E2
    cmd_valido = 1'b0;
    verifica("t6_nivel_fila", 32'(nivel), 32'd2);
    passo(2);  // E4
    reset = 1'b1;
    sb.delete();
    f0 = n_fim;
    passo(1);  // E5
    reset = 1'b0;
    verifica("t6_largura", 32'(largura), 32'd0);
    verifica("t6_nivel", 32'(nivel), 32'd0);
    verifica("t6_ocupado", 32'(ocupado), 32'd0);
    passo(15);
    verifica("t6_nfim", 32'(n_fim - f0), 32'd0);
    verifica("t6_largura_fim", 32'(largura), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
    $finish;
  end

endmodule
